// File: rtl/mem_write_arbiter_pkg.sv
// mem_write_arbiter_pkg
//   Shared definitions for the mem write-port arbiter: bus widths, default
//   sizing, arbiter state encoding and the packed {addr,data} write record.
package mem_write_arbiter_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_MAX_BURST  = 16;
  localparam int DEF_WAIT_LIMIT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/mem_write_arbiter_wr_fifo.sv
// mem_write_arbiter_wr_fifo
//   CPU store FIFO. Holds {addr,data} records in arrival order.
// Ports
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (empties the FIFO)
//   i_push   enqueue i_data
//   i_data   record to enqueue
//   i_pop    drop the head record
//   o_head   oldest record (valid while o_count != 0)
//   o_count  number of stored records, 0..DEPTH
module mem_write_arbiter_wr_fifo
  import mem_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  wr_req_t       i_data,
  input  logic          i_pop,
  output wr_req_t       o_head,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  wr_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && r_count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && r_count == '0));

endmodule

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter
//   Shares the single mem write port between the CPU (through a store FIFO,
//   never back-pressured) and a DMA engine that owns the port for bursts.
//   All mem writes leave on registered outputs one cycle after selection.
// Ports
//   clk, reset        system clock, asynchronous active-low reset
//   cpu_wen/waddr/wdata   CPU store strobe, address, data
//   dma_req           DMA wants a burst
//   dma_valid/last/waddr/wdata  DMA beat handshake and payload
//   dma_ready         beat accepted when dma_valid & dma_ready
//   dma_grant         DMA owns the port
//   mem_wen/waddr/wdata   registered write to mem
//   cpu_wpend         CPU stores still queued
//
// state     | meaning
// ARB_IDLE  | CPU owns the port; FIFO head (or a bypassed store) is issued
// ARB_BURST | DMA owns the port; CPU stores only enqueue
// ARB_DRAIN | burst over; FIFO emptied before DMA may be granted again
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_valid,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_waddr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic              dma_grant,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_wpend
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] PREEMPT_LVL = CW'(DEPTH - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [WW-1:0]     r_wait_cnt;
  logic [BW-1:0]     r_beat_cnt;
  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [DATA_W-1:0] r_mem_wdata;

  wr_req_t       w_head;
  wr_req_t       w_issue_req;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_fifo_empty;
  logic          w_below_lvl;
  logic          w_dma_ready;
  logic          w_accept;

  mem_write_arbiter_wr_fifo #(.DEPTH(DEPTH), .CW(CW)) u_wr_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  ({cpu_waddr, cpu_wdata}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_fifo_empty = (w_count == '0);
  // One free slot is kept so the store arriving in the preempt cycle still fits.
  assign w_below_lvl  = (w_count < PREEMPT_LVL);
  assign w_dma_ready  = (r_state == ARB_BURST) && w_below_lvl;
  assign w_accept     = dma_valid && w_dma_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = cpu_wen;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_issue_req = w_head;
    unique case (r_state)
      ARB_IDLE, ARB_DRAIN: begin
        if (!w_fifo_empty) begin
          w_pop   = 1'b1;
          w_issue = 1'b1;
        end else if (cpu_wen) begin
          // Empty FIFO: the store bypasses the queue to meet next-cycle latency.
          w_push      = 1'b0;
          w_issue     = 1'b1;
          w_issue_req = '{addr: cpu_waddr, data: cpu_wdata};
        end
        if (r_state == ARB_DRAIN) begin
          if (w_fifo_empty) w_state_nxt = ARB_IDLE;
        end else if (dma_req && w_below_lvl &&
                     ((w_fifo_empty && !cpu_wen) || r_wait_cnt == WW'(WAIT_LIMIT))) begin
          w_state_nxt = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (w_accept) begin
          w_issue     = 1'b1;
          w_issue_req = '{addr: dma_waddr, data: dma_wdata};
        end
        if (!w_below_lvl || !dma_req ||
            (w_accept && (dma_last || r_beat_cnt == BW'(MAX_BURST - 1)))) begin
          w_state_nxt = ARB_DRAIN;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_wait_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != ARB_BURST && w_state_nxt == ARB_BURST) begin
        r_wait_cnt <= '0;
      end else if (dma_req && r_state != ARB_BURST && r_wait_cnt != WW'(WAIT_LIMIT)) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
      if (r_state != ARB_BURST) r_beat_cnt <= '0;
      else if (w_accept)        r_beat_cnt <= r_beat_cnt + BW'(1);
      r_mem_wen <= w_issue;
      if (w_issue) begin
        r_mem_waddr <= w_issue_req.addr;
        r_mem_wdata <= w_issue_req.data;
      end
    end
  end

  assign dma_ready = w_dma_ready;
  assign dma_grant = (r_state == ARB_BURST);
  assign mem_wen   = r_mem_wen;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_wpend = !w_fifo_empty;

endmodule
